// File: rtl/video_pkg.sv
// Shared timing constants and region decode for the video timing generator.
// Default constants describe 640x480 @ 60 Hz (800 x 525 totals).
package video_pkg;

  localparam int unsigned CW = 11;            // x/y counter width
  localparam int unsigned MAX_TOTAL = 2048;   // largest total an 11-bit counter can span

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  // Regions follow each other in this order along both axes.
  typedef enum logic [1:0] {
    REG_ACTIVE,
    REG_FP,
    REG_SYNC,
    REG_BP
  } region_e;

  function automatic region_e region_of(input logic [CW-1:0] cnt,
                                        input int unsigned active,
                                        input int unsigned fp,
                                        input int unsigned sync);
    int unsigned c;
    c = 32'(cnt);
    if (c < active)                   return REG_ACTIVE;
    else if (c < active + fp)         return REG_FP;
    else if (c < active + fp + sync)  return REG_SYNC;
    else                              return REG_BP;
  endfunction

endpackage

// File: rtl/video_timing_if.sv
// Video timing bundle: pixel enable in, sync/blank/position/pulses out.
//   master: the timing generator (drives everything except ce)
//   slave : the consumer (drives ce, observes the timing)
interface video_timing_if;
  logic                     ce;
  logic                     hsync;
  logic                     vsync;
  logic                     de;
  logic [video_pkg::CW-1:0] x;
  logic [video_pkg::CW-1:0] y;
  logic                     line_start;
  logic                     frame_start;

  modport master (
    input  ce,
    output hsync, vsync, de, x, y, line_start, frame_start
  );

  modport slave (
    output ce,
    input  hsync, vsync, de, x, y, line_start, frame_start
  );
endinterface

// File: rtl/timing_axis.sv
// One axis of the raster: counter 0..TOTAL-1, region decode and wrap strobe.
//   clk, reset : pixel clock, synchronous active-high reset
//   step       : advance the counter this cycle
//   cnt        : current count (registered)
//   region_nxt : region of the count that will be held after this edge
//   wrap       : step taken while at TOTAL-1 (counter returns to 0)
module timing_axis
  import video_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step,
  output logic [CW-1:0] cnt,
  output region_e       region_nxt,
  output logic          wrap
);

  localparam int unsigned   TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [CW-1:0] LAST  = CW'(TOTAL - 1);

  if (TOTAL == 0 || TOTAL > MAX_TOTAL) begin : g_bad_total
    $error("timing_axis: total %0d outside 1..%0d", TOTAL, MAX_TOTAL);
  end

  logic [CW-1:0] cnt_nxt;

  assign wrap = step && (cnt == LAST);

  always_comb begin
    cnt_nxt = cnt;
    if (step) cnt_nxt = (cnt == LAST) ? '0 : cnt + CW'(1);
  end

  assign region_nxt = region_of(cnt_nxt, ACTIVE, FP, SYNC);

  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt_nxt;
  end

endmodule

// File: rtl/video_timing.sv
// Raster timing generator (ACTIVE, FP, SYNC, BP order on both axes).
//   clk   : pixel-domain clock
//   reset : synchronous active-high reset
//   vid   : master side of video_timing_if
//           ce in; hsync/vsync (at HS_POL/VS_POL when asserted), de, x, y,
//           line_start, frame_start out, all registered and aligned to x/y.
module video_timing
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  video_timing_if.master vid
);

  // After reset the first ce presents (0,0) as a fresh frame without moving
  // the counters; only later ce cycles advance x.
  logic          primed;
  logic          h_step;
  logic          h_wrap;
  logic          v_wrap;
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  region_e       h_reg_nxt;
  region_e       v_reg_nxt;

  assign h_step = vid.ce && primed;

  timing_axis #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk        (clk),
    .reset      (reset),
    .step       (h_step),
    .cnt        (h_cnt),
    .region_nxt (h_reg_nxt),
    .wrap       (h_wrap)
  );

  timing_axis #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk        (clk),
    .reset      (reset),
    .step       (h_wrap),
    .cnt        (v_cnt),
    .region_nxt (v_reg_nxt),
    .wrap       (v_wrap)
  );

  assign vid.x = h_cnt;
  assign vid.y = v_cnt;

  // Levels are decoded from the counts the axes will hold after this edge,
  // so registered outputs line up with x/y with no extra latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      primed          <= 1'b0;
      vid.de          <= 1'b0;
      vid.hsync       <= ~HS_POL;
      vid.vsync       <= ~VS_POL;
      vid.line_start  <= 1'b0;
      vid.frame_start <= 1'b0;
    end else begin
      vid.line_start  <= 1'b0;
      vid.frame_start <= 1'b0;
      if (vid.ce) begin
        primed          <= 1'b1;
        vid.de          <= (h_reg_nxt == REG_ACTIVE) && (v_reg_nxt == REG_ACTIVE);
        vid.hsync       <= (h_reg_nxt == REG_SYNC) ? HS_POL : ~HS_POL;
        vid.vsync       <= (v_reg_nxt == REG_SYNC) ? VS_POL : ~VS_POL;
        vid.line_start  <= !primed || h_wrap;
        vid.frame_start <= !primed || v_wrap;
      end
    end
  end

endmodule

// File: tb/tb_video_timing.sv
module tb_video_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d = 1'b1;
  logic rst_m = 1'b1;
  logic rst_s = 1'b1;

  video_timing_if vif_d ();
  video_timing_if vif_m ();
  video_timing_if vif_s ();

  // Defaults: 800 x 525
  video_timing dut (
    .clk   (clk),
    .reset (rst_d),
    .vid   (vif_d)
  );

  // Narrow lines (11 pixels), default vertical timing: full frames are cheap
  video_timing #(
    .H_ACTIVE (8),
    .H_FP     (1),
    .H_SYNC   (1),
    .H_BP     (1)
  ) dut_m (
    .clk   (clk),
    .reset (rst_m),
    .vid   (vif_m)
  );

  // Tiny raster: H 4/1/1/1 (7), V 2/1/1/1 (5)
  video_timing #(
    .H_ACTIVE (4),
    .H_FP     (1),
    .H_SYNC   (1),
    .H_BP     (1),
    .V_ACTIVE (2),
    .V_FP     (1),
    .V_SYNC   (1),
    .V_BP     (1)
  ) dut_s (
    .clk   (clk),
    .reset (rst_s),
    .vid   (vif_s)
  );

  int tests = 0;
  int fails = 0;

  // {x, y, de, hsync, vsync, line_start, frame_start}
  function automatic logic [26:0] pack(input logic [10:0] x, input logic [10:0] y,
                                       input logic de, input logic hs, input logic vs,
                                       input logic ls, input logic fs);
    return {x, y, de, hs, vs, ls, fs};
  endfunction

  function automatic logic [26:0] obs_d();
    return pack(vif_d.x, vif_d.y, vif_d.de, vif_d.hsync, vif_d.vsync, vif_d.line_start, vif_d.frame_start);
  endfunction
  function automatic logic [26:0] obs_m();
    return pack(vif_m.x, vif_m.y, vif_m.de, vif_m.hsync, vif_m.vsync, vif_m.line_start, vif_m.frame_start);
  endfunction
  function automatic logic [26:0] obs_s();
    return pack(vif_s.x, vif_s.y, vif_s.de, vif_s.hsync, vif_s.vsync, vif_s.line_start, vif_s.frame_start);
  endfunction

  // Expected outputs from hand-derived boundaries of each configuration.
  function automatic logic [26:0] exp_d(input int ex, input int ey, input bit pr, input bit ls, input bit fs);
    return pack(11'(ex), 11'(ey), pr && ex < 640 && ey < 480,
                !(ex >= 656 && ex < 752), !(ey >= 490 && ey < 492), ls, fs);
  endfunction
  function automatic logic [26:0] exp_m(input int ex, input int ey, input bit pr, input bit ls, input bit fs);
    return pack(11'(ex), 11'(ey), pr && ex < 8 && ey < 480,
                !(ex == 9), !(ey >= 490 && ey < 492), ls, fs);
  endfunction
  function automatic logic [26:0] exp_s(input int ex, input int ey, input bit pr, input bit ls, input bit fs);
    return pack(11'(ex), 11'(ey), pr && ex < 4 && ey < 2,
                !(ex == 5), !(ey == 3), ls, fs);
  endfunction

  // Reference raster position after one clock edge (reset not asserted).
  task automatic model_step(input bit ce, input int ht, input int vt,
                            inout int ex, inout int ey, inout bit pr, inout bit ls, inout bit fs);
    ls = 1'b0;
    fs = 1'b0;
    if (ce) begin
      if (!pr) begin
        pr = 1'b1;
        ls = 1'b1;
        fs = 1'b1;
      end else begin
        ex++;
        if (ex == ht) begin
          ex = 0;
          ey++;
          if (ey == vt) ey = 0;
        end
        if (ex == 0) begin
          ls = 1'b1;
          fs = (ey == 0);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int ex = 0; int ey = 0; bit pr = 0; bit ls = 0; bit fs = 0;
    logic [26:0] o;
    rst_d = 1'b1; vif_d.ce = 1'b1;
    tick(); tick();
    o = obs_d(); tests++;
    if (o !== exp_d(0, 0, 0, 0, 0)) begin fails++; $display("FAIL reset_held got=%h exp=%h", o, exp_d(0, 0, 0, 0, 0)); end
    rst_d = 1'b0;
    tick();
    model_step(1'b1, 800, 525, ex, ey, pr, ls, fs);
    o = obs_d(); tests++;
    if (o !== exp_d(0, 0, 1, 1, 1)) begin fails++; $display("FAIL reset_release got=%h exp=%h", o, exp_d(0, 0, 1, 1, 1)); end
    tick();
    model_step(1'b1, 800, 525, ex, ey, pr, ls, fs);
    o = obs_d(); tests++;
    if (o !== exp_d(1, 0, 1, 0, 0)) begin fails++; $display("FAIL reset_first_step got=%h exp=%h", o, exp_d(1, 0, 1, 0, 0)); end
  endtask

  task automatic test_line();
    int ex = 0; int ey = 0; bit pr = 0; bit ls = 0; bit fs = 0;
    int hs_low = 0; int de_hi = 0; int hmin = 9999; int hmax = -1;
    logic [26:0] o;
    rst_d = 1'b1; vif_d.ce = 1'b1;
    tick();
    rst_d = 1'b0;
    for (int k = 0; k <= 800; k++) begin
      tick();
      model_step(1'b1, 800, 525, ex, ey, pr, ls, fs);
      o = obs_d(); tests++;
      if (o !== exp_d(ex, ey, pr, ls, fs)) begin fails++; $display("FAIL line_vec k=%0d got=%h exp=%h", k, o, exp_d(ex, ey, pr, ls, fs)); end
      if (k < 800) begin
        if (vif_d.hsync === 1'b0) begin
          hs_low++;
          if (int'(vif_d.x) < hmin) hmin = int'(vif_d.x);
          if (int'(vif_d.x) > hmax) hmax = int'(vif_d.x);
        end
        if (vif_d.de === 1'b1) de_hi++;
      end
    end
    tests++; if (hs_low != 96) begin fails++; $display("FAIL line_hsync_width got=%0d exp=96", hs_low); end
    tests++; if (hmin != 656) begin fails++; $display("FAIL line_hsync_first got=%0d exp=656", hmin); end
    tests++; if (hmax != 751) begin fails++; $display("FAIL line_hsync_last got=%0d exp=751", hmax); end
    tests++; if (de_hi != 640) begin fails++; $display("FAIL line_de_count got=%0d exp=640", de_hi); end
    tests++; if (vif_d.y !== 11'd1) begin fails++; $display("FAIL line_y_advance got=%0d exp=1", vif_d.y); end
  endtask

  task automatic test_frame();
    int ex = 0; int ey = 0; bit pr = 0; bit ls = 0; bit fs = 0;
    int fs_cnt = 0; int vs_low = 0; int vmin = 9999; int vmax = -1;
    logic [26:0] o;
    rst_m = 1'b1; vif_m.ce = 1'b1;
    tick();
    rst_m = 1'b0;
    for (int k = 0; k < 11550; k++) begin
      tick();
      model_step(1'b1, 11, 525, ex, ey, pr, ls, fs);
      o = obs_m(); tests++;
      if (o !== exp_m(ex, ey, pr, ls, fs)) begin fails++; $display("FAIL frame_vec k=%0d got=%h exp=%h", k, o, exp_m(ex, ey, pr, ls, fs)); end
      if (vif_m.frame_start === 1'b1) fs_cnt++;
      if (vif_m.vsync === 1'b0) begin
        vs_low++;
        if (int'(vif_m.y) < vmin) vmin = int'(vif_m.y);
        if (int'(vif_m.y) > vmax) vmax = int'(vif_m.y);
      end
    end
    tests++; if (fs_cnt != 2) begin fails++; $display("FAIL frame_start_count got=%0d exp=2", fs_cnt); end
    tests++; if (vs_low != 44) begin fails++; $display("FAIL frame_vsync_cycles got=%0d exp=44", vs_low); end
    tests++; if (vmin != 490) begin fails++; $display("FAIL frame_vsync_first got=%0d exp=490", vmin); end
    tests++; if (vmax != 491) begin fails++; $display("FAIL frame_vsync_last got=%0d exp=491", vmax); end
  endtask

  task automatic test_ce_sparse();
    int ex = 0; int ey = 0; bit pr = 0; bit ls = 0; bit fs = 0;
    int ls_cnt = 0; int fs_cnt = 0;
    logic [26:0] o;
    rst_d = 1'b1; vif_d.ce = 1'b0;
    tick();
    rst_d = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      model_step(1'b0, 800, 525, ex, ey, pr, ls, fs);
      o = obs_d(); tests++;
      if (o !== exp_d(0, 0, 0, 0, 0)) begin fails++; $display("FAIL sparse_idle k=%0d got=%h exp=%h", k, o, exp_d(0, 0, 0, 0, 0)); end
    end
    for (int c = 0; c < 100; c++) begin
      vif_d.ce = (c % 4 == 0);
      tick();
      model_step(c % 4 == 0, 800, 525, ex, ey, pr, ls, fs);
      o = obs_d(); tests++;
      if (o !== exp_d(ex, ey, pr, ls, fs)) begin fails++; $display("FAIL sparse_vec c=%0d got=%h exp=%h", c, o, exp_d(ex, ey, pr, ls, fs)); end
      if (vif_d.line_start === 1'b1) ls_cnt++;
      if (vif_d.frame_start === 1'b1) fs_cnt++;
    end
    vif_d.ce = 1'b0;
    tests++; if (ls_cnt != 1) begin fails++; $display("FAIL sparse_line_pulses got=%0d exp=1", ls_cnt); end
    tests++; if (fs_cnt != 1) begin fails++; $display("FAIL sparse_frame_pulses got=%0d exp=1", fs_cnt); end
    tests++; if (vif_d.x !== 11'd24) begin fails++; $display("FAIL sparse_x_final got=%0d exp=24", vif_d.x); end
  endtask

  task automatic test_small();
    int ex = 0; int ey = 0; bit pr = 0; bit ls = 0; bit fs = 0;
    int ls_cnt = 0; int fs_cnt = 0; int xmax = -1; int ymax = -1;
    logic [26:0] o;
    rst_s = 1'b1; vif_s.ce = 1'b1;
    tick();
    rst_s = 1'b0;
    for (int k = 0; k <= 70; k++) begin
      tick();
      model_step(1'b1, 7, 5, ex, ey, pr, ls, fs);
      o = obs_s(); tests++;
      if (o !== exp_s(ex, ey, pr, ls, fs)) begin fails++; $display("FAIL small_vec k=%0d got=%h exp=%h", k, o, exp_s(ex, ey, pr, ls, fs)); end
      if (vif_s.line_start === 1'b1) ls_cnt++;
      if (vif_s.frame_start === 1'b1) fs_cnt++;
      if (int'(vif_s.x) > xmax) xmax = int'(vif_s.x);
      if (int'(vif_s.y) > ymax) ymax = int'(vif_s.y);
    end
    tests++; if (ls_cnt != 11) begin fails++; $display("FAIL small_line_pulses got=%0d exp=11", ls_cnt); end
    tests++; if (fs_cnt != 3) begin fails++; $display("FAIL small_frame_pulses got=%0d exp=3", fs_cnt); end
    tests++; if (xmax != 6) begin fails++; $display("FAIL small_x_max got=%0d exp=6", xmax); end
    tests++; if (ymax != 4) begin fails++; $display("FAIL small_y_max got=%0d exp=4", ymax); end
    for (int c = 0; c < 80; c++) begin
      vif_s.ce = (c % 2 == 0);
      tick();
      model_step(c % 2 == 0, 7, 5, ex, ey, pr, ls, fs);
      o = obs_s(); tests++;
      if (o !== exp_s(ex, ey, pr, ls, fs)) begin fails++; $display("FAIL small_sparse_vec c=%0d got=%h exp=%h", c, o, exp_s(ex, ey, pr, ls, fs)); end
    end
  endtask

  task automatic test_reset_mid();
    logic [26:0] o;
    // Narrow instance: reset at x=5, y=200 (2205 advances after the priming ce)
    rst_m = 1'b1; vif_m.ce = 1'b1;
    tick();
    rst_m = 1'b0;
    for (int k = 0; k <= 2205; k++) tick();
    o = obs_m(); tests++;
    if (o !== exp_m(5, 200, 1, 0, 0)) begin fails++; $display("FAIL mid_m_position got=%h exp=%h", o, exp_m(5, 200, 1, 0, 0)); end
    rst_m = 1'b1;
    tick();
    o = obs_m(); tests++;
    if (o !== exp_m(0, 0, 0, 0, 0)) begin fails++; $display("FAIL mid_m_reset got=%h exp=%h", o, exp_m(0, 0, 0, 0, 0)); end
    rst_m = 1'b0;
    tick();
    o = obs_m(); tests++;
    if (o !== exp_m(0, 0, 1, 1, 1)) begin fails++; $display("FAIL mid_m_restart got=%h exp=%h", o, exp_m(0, 0, 1, 1, 1)); end
    tick();
    o = obs_m(); tests++;
    if (o !== exp_m(1, 0, 1, 0, 0)) begin fails++; $display("FAIL mid_m_step got=%h exp=%h", o, exp_m(1, 0, 1, 0, 0)); end
    // Default instance: reset at x=300 with ce still high
    rst_d = 1'b1; vif_d.ce = 1'b1;
    tick();
    rst_d = 1'b0;
    for (int k = 0; k <= 300; k++) tick();
    o = obs_d(); tests++;
    if (o !== exp_d(300, 0, 1, 0, 0)) begin fails++; $display("FAIL mid_d_position got=%h exp=%h", o, exp_d(300, 0, 1, 0, 0)); end
    rst_d = 1'b1;
    tick();
    o = obs_d(); tests++;
    if (o !== exp_d(0, 0, 0, 0, 0)) begin fails++; $display("FAIL mid_d_reset got=%h exp=%h", o, exp_d(0, 0, 0, 0, 0)); end
    rst_d = 1'b0;
    tick();
    o = obs_d(); tests++;
    if (o !== exp_d(0, 0, 1, 1, 1)) begin fails++; $display("FAIL mid_d_restart got=%h exp=%h", o, exp_d(0, 0, 1, 1, 1)); end
  endtask

  initial begin
    vif_d.ce = 1'b0;
    vif_m.ce = 1'b0;
    vif_s.ce = 1'b0;
    test_reset();
    test_line();
    test_frame();
    test_ce_sparse();
    test_small();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
